// File: rtl/hack_cpu_mc.sv
// Multicycle Hack CPU core. Instructions are fetched over a req/ack port and
// M operands travel over a separate req/ack data port, so either memory may
// stall the core. An instruction commits (A/D/pc update) in a single edge,
// flagged by a one-cycle retire pulse.
module hack_cpu_mc #(
    parameter int          DW       = 16,
    parameter int          AW       = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rstn,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic          dmem_rd,
    output logic          dmem_wr,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic [AW-1:0] pc,
    output logic          retire
);

    localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MREAD,
        S_EXEC,
        S_MWRITE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] d_q, d_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] m_q, m_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          imem_req_q, imem_req_d;
    logic          dmem_rd_q, dmem_rd_d;
    logic          dmem_wr_q, dmem_wr_d;

    logic [DW-1:0] alu_x, alu_y, alu_out, result;
    logic          zr, ng, jmp, commit;

    // Hack ALU: x is always D, y is M when the a-bit is set, else A.
    always_comb begin
        alu_x = d_q;
        alu_y = ir_q[12] ? m_q : a_q;
        if (ir_q[11]) alu_x = '0;
        if (ir_q[10]) alu_x = ~alu_x;
        if (ir_q[9])  alu_y = '0;
        if (ir_q[8])  alu_y = ~alu_y;
        alu_out = ir_q[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (ir_q[6])  alu_out = ~alu_out;
    end

    // In MWRITE the ALU result was latched into wdata_q; D, A and Mreg have
    // not moved since EXEC, so it is identical to a fresh ALU evaluation.
    assign result = (state_q == S_MWRITE) ? wdata_q : alu_out;
    assign zr     = (result == '0);
    assign ng     = result[DW-1];
    assign jmp    = (ng & ir_q[2]) | (zr & ir_q[1]) | (~ng & ~zr & ir_q[0]);

    // Next-state logic; jump target and store address use the pre-commit A.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        d_d     = d_q;
        ir_d    = ir_q;
        m_d     = m_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!ir_q[DW-1]) begin
                    a_d         = ir_q;
                    a_d[DW-1]   = 1'b0;
                    pc_d        = pc_q + 1'b1;
                    retire      = 1'b1;
                    state_d     = S_FETCH;
                end else if (ir_q[12]) begin
                    state_d = S_MREAD;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MREAD: begin
                if (dmem_rd_q && dmem_ack) begin
                    m_d     = dmem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ir_q[3]) begin
                    wdata_d = alu_out;
                    state_d = S_MWRITE;
                end else begin
                    commit = 1'b1;
                end
            end
            S_MWRITE: begin
                if (dmem_wr_q && dmem_ack) commit = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        if (commit) begin
            if (ir_q[4]) d_d = result;
            if (ir_q[5]) a_d = result;
            pc_d    = jmp ? a_q[AW-1:0] : pc_q + 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
        end
        // Requests are registered from the state being entered, so they are
        // high for exactly the cycles spent waiting in that state.
        imem_req_d = (state_d == S_FETCH);
        dmem_rd_d  = (state_d == S_MREAD);
        dmem_wr_d  = (state_d == S_MWRITE);
    end

    // State and architectural registers; reset drops any pending request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_FETCH;
            pc_q       <= PC_RST;
            a_q        <= '0;
            d_q        <= '0;
            ir_q       <= '0;
            m_q        <= '0;
            wdata_q    <= '0;
            imem_req_q <= 1'b0;
            dmem_rd_q  <= 1'b0;
            dmem_wr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            a_q        <= a_d;
            d_q        <= d_d;
            ir_q       <= ir_d;
            m_q        <= m_d;
            wdata_q    <= wdata_d;
            imem_req_q <= imem_req_d;
            dmem_rd_q  <= dmem_rd_d;
            dmem_wr_q  <= dmem_wr_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign dmem_rd    = dmem_rd_q;
    assign dmem_wr    = dmem_wr_q;
    assign dmem_addr  = a_q[AW-1:0];
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: memory responders with programmable ack latency, an
// instruction-level reference model run at fetch time that pushes expected
// post-commit state, and a monitor that pops and compares on every retire.
module tb_hack_cpu_mc;

    localparam int DW = 16;
    localparam int AW = 15;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          imem_req, imem_ack;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          dmem_rd, dmem_wr, dmem_ack;
    logic [AW-1:0] dmem_addr, pc;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          retire;

    // second instance at DW=24
    logic          imem_req2, dmem_rd2, dmem_wr2, retire2;
    logic [AW-1:0] imem_addr2, dmem_addr2, pc2;
    logic [23:0]   dmem_wdata2;
    logic [23:0]   imem_rdata2 = 24'h3FFFFF;
    logic [23:0]   dmem_rdata2 = 24'h0;
    logic          dmem_ack2 = 1'b0;

    always #5 clk = ~clk;

    hack_cpu_mc #(.DW(DW), .AW(AW), .RESET_PC(0)) dut (
        .clk(clk), .rstn(rstn),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc(pc), .retire(retire)
    );

    hack_cpu_mc #(.DW(24), .AW(AW), .RESET_PC(0)) dut2 (
        .clk(clk), .rstn(rstn),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_req2), .imem_rdata(imem_rdata2),
        .dmem_rd(dmem_rd2), .dmem_wr(dmem_wr2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
        .dmem_ack(dmem_ack2), .dmem_rdata(dmem_rdata2), .pc(pc2), .retire(retire2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [AW-1:0] pc; logic [DW-1:0] a; logic [DW-1:0] d; int lat; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } st_t;
    exp_t          exp_q[$];
    st_t           st_q[$];
    logic [AW-1:0] rd_q[$];

    logic [DW-1:0] imem [0:MSZ-1];
    logic [DW-1:0] dmem [0:MSZ-1];
    logic [DW-1:0] mmem [0:MSZ-1];
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_a, m_d;

    int ilat = 0, dlat = 0, icnt = 0, dcnt = 0;
    logic i_ack = 1'b0, d_ack = 1'b0, inj_ack = 1'b0;
    logic [DW-1:0] i_rdata = '0, d_rdata = '0;
    assign imem_ack   = i_ack;
    assign imem_rdata = i_rdata;
    assign dmem_ack   = d_ack | inj_ack;
    assign dmem_rdata = d_rdata;

    int cyc = 0, retired = 0, last_ret = 0;
    bit first = 1'b1;

    // Reference model: execute one instruction, push expected outcome.
    task automatic model_exec(input logic [DW-1:0] ins);
        logic [DW-1:0] x, y, o;
        logic [AW-1:0] aold;
        logic          lt, eq, gt, take;
        int            lat;
        exp_t          e;
        chk("fetch_addr", imem_addr, m_pc);
        aold = m_a[AW-1:0];
        if (!ins[15]) begin
            m_a  = {1'b0, ins[14:0]};
            m_pc = m_pc + 1'b1;
            lat  = 2;
        end else begin
            lat = 3;
            if (ins[12]) begin
                rd_q.push_back(aold);
                y = mmem[aold];
                lat += 1 + dlat;
            end else begin
                y = m_a;
            end
            x = m_d;
            if (ins[11]) x = '0;
            if (ins[10]) x = ~x;
            if (ins[9])  y = '0;
            if (ins[8])  y = ~y;
            o = ins[7] ? x + y : x & y;
            if (ins[6])  o = ~o;
            if (ins[3]) begin
                mmem[aold] = o;
                st_q.push_back('{addr: aold, data: o});
                lat += 1 + dlat;
            end
            lt = o[15];
            eq = (o == '0);
            gt = !lt && !eq;
            take = (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
            m_pc = take ? aold : m_pc + 1'b1;
            if (ins[4]) m_d = o;
            if (ins[5]) m_a = o;
        end
        e = '{pc: m_pc, a: m_a, d: m_d, lat: lat + ilat};
        exp_q.push_back(e);
    endtask

    // Memory responders: ack after a programmable number of wait cycles.
    always @(posedge clk) begin
        #1;
        i_ack = 1'b0;
        if (rstn && imem_req) begin
            if (icnt == ilat) begin
                i_ack   = 1'b1;
                i_rdata = imem[imem_addr];
                icnt    = 0;
                model_exec(imem[imem_addr]);
            end else begin
                icnt++;
            end
        end else begin
            icnt = 0;
        end
        d_ack = 1'b0;
        if (rstn && (dmem_rd || dmem_wr)) begin
            if (dcnt == dlat) begin
                d_ack = 1'b1;
                if (dmem_rd) d_rdata = dmem[dmem_addr];
                else         dmem[dmem_addr] = dmem_wdata;
                dcnt = 0;
            end else begin
                dcnt++;
            end
        end else begin
            dcnt = 0;
        end
    end

    always @(posedge clk) cyc++;

    // Monitor: data port stability, retire timing, and post-commit state.
    always begin
        exp_t e;
        @(negedge clk);
        if (rstn) begin
            if (dmem_wr) begin
                if (st_q.size() == 0) chk("unexpected_wr", 1, 0);
                else begin
                    chk("wr_addr", dmem_addr, st_q[0].addr);
                    chk("wr_data", dmem_wdata, st_q[0].data);
                    chk("retire_on_wr_ack", retire, dmem_ack);
                    if (dmem_ack) void'(st_q.pop_front());
                end
            end
            if (dmem_rd) begin
                if (rd_q.size() == 0) chk("unexpected_rd", 1, 0);
                else begin
                    chk("rd_addr", dmem_addr, rd_q[0]);
                    if (dmem_ack) void'(rd_q.pop_front());
                end
            end
            if (retire) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (!first) chk("latency", cyc - last_ret, e.lat);
                    first    = 1'b0;
                    last_ret = cyc;
                    @(posedge clk);
                    #2;
                    $display("retire pc=%h A=%h D=%h", pc, dut.a_q, dut.d_q);
                    chk("pc", pc, e.pc);
                    chk("A", dut.a_q, e.a);
                    chk("D", dut.d_q, e.d);
                end
                retired++;
            end
        end
    end

    task automatic flush_model();
        exp_q.delete();
        st_q.delete();
        rd_q.delete();
        m_pc  = '0;
        m_a   = '0;
        m_d   = '0;
        first = 1'b1;
    endtask

    task automatic init_dmem();
        for (int i = 0; i < MSZ; i++) begin
            dmem[i] = '0;
            mmem[i] = '0;
        end
        dmem[200] = 16'hFFFF;
        mmem[200] = 16'hFFFF;
    endtask

    task automatic check_reset_outputs(input string phase);
        chk({phase, "_imem_req"}, imem_req, 0);
        chk({phase, "_dmem_rd"}, dmem_rd, 0);
        chk({phase, "_dmem_wr"}, dmem_wr, 0);
        chk({phase, "_retire"}, retire, 0);
        chk({phase, "_imem_addr"}, imem_addr, 0);
        chk({phase, "_pc"}, pc, 0);
        chk({phase, "_dmem_addr"}, dmem_addr, 0);
        chk({phase, "_dmem_wdata"}, dmem_wdata, 0);
    endtask

    task automatic do_reset(input string phase);
        rstn = 1'b0;
        #1;
        check_reset_outputs(phase);
        flush_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk({phase, "_req_rise"}, imem_req, 1);
    endtask

    task automatic run_retires(input int n, input int budget);
        int start;
        start = retired;
        for (int c = 0; c < budget && (retired - start) < n; c++) @(posedge clk);
        if ((retired - start) < n) chk("retire_timeout", retired - start, n);
        #1;
    endtask

    initial begin
        for (int i = 0; i < MSZ; i++) imem[i] = '0;
        init_dmem();
        imem[0]  = 16'h0005;  // @5
        imem[1]  = 16'h0007;  // @7
        imem[2]  = 16'hEC10;  // D=A
        imem[3]  = 16'hE090;  // D=D+A
        imem[4]  = 16'h0064;  // @100
        imem[5]  = 16'hE308;  // M=D
        imem[6]  = 16'h00C8;  // @200
        imem[7]  = 16'hFC10;  // D=M
        imem[8]  = 16'h0014;  // @20
        imem[9]  = 16'hE304;  // D;JLT
        imem[20] = 16'h0064;  // @100
        imem[21] = 16'hFDE8;  // AM=M+1
        imem[22] = 16'hEA90;  // D=0
        imem[23] = 16'h001E;  // @30
        imem[24] = 16'hE302;  // D;JEQ
        imem[30] = 16'h7FFF;  // @32767
        imem[31] = 16'hEA87;  // 0;JMP
        imem[MSZ-1] = 16'hEA90;  // D=0, falls through and wraps

        // zero-wait memories through the whole program, including wrap
        ilat = 0; dlat = 0;
        do_reset("rst1");
        run_retires(18, 500);
        chk("pc_wrapped", pc, 0);
        chk("mem100_final", dmem[100], 16'd15);
        chk("A_after_AM_chain", dut.a_q, 16'h7FFF);

        // stalling memories on the first part of the program
        init_dmem();
        ilat = 1; dlat = 2;
        do_reset("rst2");
        run_retires(10, 500);
        chk("pc_after_jlt", pc, 20);
        chk("D_after_read", dut.d_q, 16'hFFFF);
        chk("mem100_slow_store", dmem[100], 16'd14);

        // reset while a data read is outstanding, then a stray ack
        init_dmem();
        imem[0] = 16'h00C8;  // @200
        imem[1] = 16'hFC10;  // D=M
        ilat = 0; dlat = 50;
        do_reset("rst3");
        for (int c = 0; c < 100 && !dmem_rd; c++) @(negedge clk);
        chk("rd_pending", dmem_rd, 1);
        chk("A_before_abort", dut.a_q, 200);
        #1;
        rstn = 1'b0;
        #1;
        check_reset_outputs("abort");
        chk("abort_A", dut.a_q, 0);
        chk("abort_D", dut.d_q, 0);
        flush_model();
        dlat = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn    = 1'b1;
        inj_ack = 1'b1;
        @(posedge clk);
        #1;
        inj_ack = 1'b0;
        chk("late_ack_A", dut.a_q, 0);
        chk("late_ack_D", dut.d_q, 0);
        chk("late_ack_pc", pc, 0);
        chk("late_ack_rd", dmem_rd, 0);
        chk("late_ack_req", imem_req, 1);
        run_retires(2, 200);
        chk("D_after_restart", dut.d_q, 16'hFFFF);

        // wide-data instance has been executing @0x3FFFFF all along
        chk("dw24_A", dut2.a_q, 32'h3FFFFF);
        chk("dw24_D", dut2.d_q, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
